// File: rtl/enc_16to4_pending_if.sv
// Bus bundle for enc_16to4_pending: request capture, valid/ready code output and status.
// Handshake: a code transfers on a rising clk edge where valid_out=1 and ready_in=1;
// while valid_out=1 and ready_in=0, code_out and valid_out hold steady.
interface enc_16to4_pending_if #(
   parameter int WIDTH  = 16,
   parameter int CODE_W = 4
) ();
   logic              enable;
   logic [WIDTH-1:0]  req_in;
   logic [CODE_W-1:0] code_out;
   logic              valid_out;
   logic              ready_in;
   logic [WIDTH-1:0]  pending_out;
   logic              any_pending;
   logic              overrun;
   logic              clr_ovr;

   modport master (
      output enable, req_in, ready_in, clr_ovr,
      input  code_out, valid_out, pending_out, any_pending, overrun
   );

   modport slave (
      input  enable, req_in, ready_in, clr_ovr,
      output code_out, valid_out, pending_out, any_pending, overrun
   );
endinterface

// File: rtl/enc_16to4_pending.sv
// Edge-capturing 16-to-4 event encoder with sticky pending bits and a registered valid/ready stage.
// Define ENC_ROUND_ROBIN_EN to rotate the search start past the last issued index.
module enc_16to4_pending #(
   parameter int WIDTH  = 16,
   parameter int CODE_W = 4
) (
   input logic                clk,
   input logic                rst,
   enc_16to4_pending_if.slave bus
);

   logic [WIDTH-1:0]  req_prev_q, req_prev_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;

   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  issue_mask;
   logic [CODE_W-1:0] sel_idx;
   logic              stage_free;
   logic              issue;

`ifdef ENC_ROUND_ROBIN_EN
   logic [CODE_W-1:0] last_idx_q, last_idx_d;
   logic [CODE_W-1:0] cand;
   logic              found;

   // Search begins one past the last issued index and wraps modulo WIDTH.
   always_comb begin
      sel_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < WIDTH; k++) begin
         cand = last_idx_q + CODE_W'(k + 1);
         if (!found && pending_q[cand]) begin
            sel_idx = cand;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      last_idx_d = last_idx_q;
      if (issue) last_idx_d = sel_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_idx_q <= CODE_W'(WIDTH - 1);
      else     last_idx_q <= last_idx_d;
   end
`else
   // Descending scan so the lowest set bit is the one left in sel_idx.
   always_comb begin
      sel_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending_q[i]) sel_idx = CODE_W'(i);
      end
   end
`endif

   always_comb begin
      rise       = bus.req_in & ~req_prev_q & {WIDTH{bus.enable}};
      stage_free = ~valid_q | bus.ready_in;
      issue      = stage_free & (|pending_q);
      issue_mask = '0;
      if (issue) issue_mask[sel_idx] = 1'b1;
   end

   // A fresh rise on a bit being issued this cycle re-arms it rather than counting as overrun.
   always_comb begin
      req_prev_d = bus.req_in;
      pending_d  = (pending_q & ~issue_mask) | rise;
      overrun_d  = (overrun_q & ~bus.clr_ovr) | (|(rise & pending_q & ~issue_mask));
      valid_d    = valid_q;
      code_d     = code_q;
      if (stage_free) begin
         valid_d = issue;
         if (issue) code_d = sel_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_prev_q <= '0;
         pending_q  <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         req_prev_q <= req_prev_d;
         pending_q  <= pending_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.code_out    = code_q;
   assign bus.valid_out   = valid_q;
   assign bus.pending_out = pending_q;
   assign bus.any_pending = |pending_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_enc_16to4_pending.sv
// Self-checking bench for enc_16to4_pending: expected codes queued at stimulus, popped on handshake.
module tb_enc_16to4_pending;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [3:0] exp_q[$];

   enc_16to4_pending_if #(.WIDTH(16), .CODE_W(4)) bus ();

   enc_16to4_pending #(.WIDTH(16), .CODE_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.enable   = 1'b1;
      bus.req_in   = '0;
      bus.ready_in = 1'b1;
      bus.clr_ovr  = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic drain(input string tag, input int cycles);
      repeat (cycles) step();
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // scoreboard: compare each accepted code against the queue head
   always @(negedge clk) begin
      if (!rst && bus.valid_out && bus.ready_in) begin
         if (exp_q.size() == 0) check("spurious_code", exp_q.size(), 1);
         else check("code_seq", bus.code_out, exp_q.pop_front());
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;

      do_reset();
      check("rst_valid", bus.valid_out, 0);
      check("rst_code", bus.code_out, 0);
      check("rst_pending", bus.pending_out, 0);
      check("rst_any", bus.any_pending, 0);
      check("rst_ovr", bus.overrun, 0);

      // single edge on bit 5
      bus.req_in = 16'h0020;
      exp_q.push_back(4'd5);
      step();
      check("t1_pending", bus.pending_out, 16'h0020);
      check("t1_any", bus.any_pending, 1);
      check("t1_valid_e0", bus.valid_out, 0);
      step();
      check("t1_valid_e1", bus.valid_out, 1);
      check("t1_code", bus.code_out, 5);
      check("t1_pend_clr", bus.pending_out, 0);
      step();
      check("t1_valid_done", bus.valid_out, 0);
      drain("t1_drain", 2);

      // simultaneous edges
      do_reset();
      bus.req_in = 16'h8101;
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd15);
      repeat (5) step();
      check("t2_valid_end", bus.valid_out, 0);
      check("t2_pend_end", bus.pending_out, 0);
      drain("t2_drain", 1);

      // backpressure
      do_reset();
      bus.ready_in = 1'b0;
      bus.req_in   = 16'h0006;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd2);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", bus.valid_out, 1);
         check("t3_hold_code", bus.code_out, 1);
         check("t3_hold_pend", bus.pending_out, 16'h0004);
         step();
      end
      bus.ready_in = 1'b1;
      step();
      check("t3_code2", bus.code_out, 2);
      check("t3_valid2", bus.valid_out, 1);
      step();
      check("t3_valid_end", bus.valid_out, 0);
      drain("t3_drain", 1);

      // enable gating
      do_reset();
      bus.enable = 1'b0;
      bus.req_in = 16'h0018;
      repeat (3) step();
      check("t4_gated_pend", bus.pending_out, 0);
      check("t4_gated_valid", bus.valid_out, 0);
      bus.req_in = '0;
      bus.enable = 1'b1;
      step();
      bus.req_in = 16'h0010;
      exp_q.push_back(4'd4);
      drain("t4_drain", 4);

      // overrun and re-arm
      do_reset();
      bus.ready_in = 1'b0;
      bus.req_in   = 16'h0002;
      exp_q.push_back(4'd1);
      step();
      step();
      bus.req_in = 16'h0082;
      step();
      check("t5_pend7", bus.pending_out, 16'h0080);
      check("t5_ovr_clean", bus.overrun, 0);
      bus.req_in = 16'h0002;
      step();
      bus.req_in = 16'h0082;
      step();
      check("t5_ovr_set", bus.overrun, 1);
      check("t5_pend7_b", bus.pending_out, 16'h0080);
      check("t5_hold_code", bus.code_out, 1);
      bus.clr_ovr = 1'b1;
      step();
      bus.clr_ovr = 1'b0;
      check("t5_ovr_clr", bus.overrun, 0);
      bus.req_in = 16'h0002;
      step();
      bus.ready_in = 1'b1;
      bus.req_in   = 16'h0082;
      exp_q.push_back(4'd7);
      exp_q.push_back(4'd7);
      step();
      check("t5_rearm_pend", bus.pending_out, 16'h0080);
      check("t5_rearm_code", bus.code_out, 7);
      check("t5_rearm_ovr", bus.overrun, 0);
      step();
      check("t5_second7", bus.code_out, 7);
      check("t5_second7_v", bus.valid_out, 1);
      check("t5_pend_end", bus.pending_out, 0);
      drain("t5_drain", 2);

      // async reset mid-operation
      do_reset();
      bus.ready_in = 1'b0;
      bus.req_in   = 16'hFFFF;
      exp_q.push_back(4'd0);
      step();
      check("t6_pend_full", bus.pending_out, 16'hFFFF);
      step();
      check("t6_valid", bus.valid_out, 1);
      #2;
      rst        = 1'b1;
      bus.req_in = '0;
      exp_q.delete();
      #1;
      check("t6_rst_valid", bus.valid_out, 0);
      check("t6_rst_pend", bus.pending_out, 0);
      check("t6_rst_any", bus.any_pending, 0);
      check("t6_rst_code", bus.code_out, 0);
      step();
      rst          = 1'b0;
      bus.ready_in = 1'b1;
      repeat (4) step();
      check("t6_quiet_valid", bus.valid_out, 0);
      check("t6_quiet_pend", bus.pending_out, 0);
      bus.req_in = 16'h0200;
      exp_q.push_back(4'd9);
      drain("t6_drain", 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/enc_16to4_pending.md
Name: enc_16to4_pending

Overview:
- Encoder counterpart to the team's 4-bit-to-16-line decoder: converts 16 one-bit event lines back into a 4-bit binary index.
- Rising edges on the request lines are latched into a sticky pending register.
- Pending events are issued one at a time, lowest index first, through a registered valid/ready output stage.
- Used wherever decoder-driven lines must be reported back as a compact code (event/interrupt aggregation).

Parameters:
- WIDTH, 16, number of request lines; must equal 2**CODE_W.
- CODE_W, 4, width of the encoded index output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- enable  input  1  1 = capture new request edges; 0 = ignore new edges, keep serving existing pending events
- req_in  input  WIDTH  request lines, synchronous to clk
- code_out  output  CODE_W  encoded index of the issued event
- valid_out  output  1  code_out holds an unconsumed event
- ready_in  input  1  consumer accepts code_out when valid_out=1 and ready_in=1
- pending_out  output  WIDTH  current pending register, for debug and status
- any_pending  output  1  OR-reduction of pending_out
- overrun  output  1  sticky flag: an edge arrived on a line that was already pending
- clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, immediate): code_out=0, valid_out=0, pending=0, any_pending=0, overrun=0, req_prev=0.
- Edge detect: rise = req_in & ~req_prev & {WIDTH{enable}}. req_prev <= req_in every cycle, regardless of enable.
- Pending update per cycle: pending <= (pending & ~issue_mask) | rise.
  - If a bit is both issued and rising in the same cycle, set wins; the bit stays pending as a new event.
- Overrun: set when (rise & pending & ~issue_mask) != 0.
  - clr_ovr clears it; if a set and clr_ovr occur in the same cycle, set wins.
- Output stage is free when valid_out=0, or when valid_out=1 and ready_in=1.
- When the stage is free and pending != 0:
  - code_out <= index of the lowest set pending bit; valid_out <= 1; issue_mask = one-hot of that index.
  - Otherwise issue_mask = 0.
- When the stage is free and pending == 0: valid_out <= 0; code_out holds its last value.
- Hold rule: while valid_out=1 and ready_in=0, code_out and valid_out are stable.
- Latency: a rise sampled at edge E0 sets pending; valid_out rises after edge E1 if the stage is free. Minimum 2 edges from req_in rising to valid_out.
- Throughput: one code per cycle with ready_in held high.
- Priority is static: index 0 is highest, index WIDTH-1 is lowest.
- Edge case: req_in bit 0 rising alone yields code_out=0 with valid_out=1. valid_out, not code_out, distinguishes an event from no event.
- Reset mid-operation clears all pending events; no code is issued after reset until a new rise occurs.
- enable=0 does not flush pending events and does not block issue.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined:
  - Add a CODE_W-bit last_idx register, reset to WIDTH-1.
  - The search starts at (last_idx+1) mod WIDTH and wraps through WIDTH-1 back to 0.
  - last_idx <= issued index on each issue.
- Undefined: static lowest-index-first priority as above, and no last_idx register.

Test Plan:
- Reset then a single edge: req_in 0x0000 -> 0x0020, ready_in=1 -> after 2 edges, valid_out=1 and code_out=5 for one cycle; pending returns to 0x0000.
- Simultaneous edges: req_in 0x0000 -> 0x8101, ready_in=1 -> codes 0, 8, 15 on consecutive cycles, then valid_out=0. With ENC_ROUND_ROBIN_EN and last_idx=3, the order is 8, 15, 0.
- Backpressure: pending 0x0006, ready_in=0 -> code_out=1 with valid_out=1 held stable for 5 cycles. Raise ready_in -> code 2 on the next cycle, then valid_out=0.
- Enable gating: enable=0 with req_in rising on bits 3 and 4 -> pending stays 0 and valid_out stays 0. Drop req_in, set enable=1, re-raise bit 4 -> code 4.
- Overrun and re-arm: bit 7 pending and ready_in=0; bit 7 falls and rises again -> overrun=1. Pulse clr_ovr -> overrun=0. A rise on bit 7 in the same cycle it issues -> pending bit 7 stays 1, and a second code 7 follows.
- Async reset mid-operation: pending 0xFFFF, valid_out=1; assert rst between clock edges -> all outputs 0 immediately. Release rst -> no valid_out until a new rise occurs.
